mem_access_master: RTL and testbench
====================================

// Module: mem_access_master
// PURPOSE
//   CPU-side initiator for the unified instruction/data memory of the multi-cycle CPU.
//   Accepts one fetch/load/store request at a time from the control unit.
//   Checks the address and drives Address/Write_data/MemRead/MemWrite for exactly one cycle.
//   Captures combinational Mem_data into the instruction register (fetch) or memory data register (load).
//   Reports completion and access errors so the control FSM can raise an exception.
// PARAMETERS
//   RAM_SIZE       256  words in the memory
//   RAM_SIZE_BIT   8    log2(RAM_SIZE); word index = addr[RAM_SIZE_BIT+1:2]
//   RAM_INST_SIZE  32   words 0..RAM_INST_SIZE-1 form the write-protected instruction region
// PORTS
//   clk          in   1   system clock, all state on posedge
//   reset        in   1   synchronous, active-high
//   req_valid    in   1   request present; sampled only when ready=1
//   req_op       in   2   00 fetch, 01 load, 10 store, 11 reserved
//   req_addr     in   32  byte address
//   req_wdata    in   32  store data
//   ready        out  1   1 when in IDLE (request can be accepted)
//   done         out  1   one-cycle completion pulse (success or error)
//   err          out  1   valid with done: request was rejected
//   err_code     out  2   00 none, 01 misaligned, 10 out of range, 11 protected store/reserved op
//   inst_reg     out  32  last fetched instruction
//   mem_data_reg out  32  last loaded word
//   Address      out  32  to memory
//   Write_data   out  32  to memory
//   MemRead      out  1   to memory
//   MemWrite     out  1   to memory; memory commits write on next posedge
//   Mem_data     in   32  from memory, combinational (0 when MemRead=0)
// BEHAVIOUR
//   States: IDLE, ACCESS. Reset value: IDLE. All outputs are 0 except ready=1.
//   IDLE: ready=1; MemRead=MemWrite=0; Address=latched address; Write_data=latched data.
//     A posedge with req_valid=1 latches req_op, req_addr and req_wdata.
//     The same posedge computes err_code and moves to ACCESS.
//   Error priority: reserved op (11) > misaligned (addr[1:0]!=0) > out of range (addr[31:RAM_SIZE_BIT+2]!=0)
//     > protected store (op=store and word index < RAM_INST_SIZE).
//   ACCESS (exactly 1 cycle): ready=0.
//     If no error: MemRead=1 for fetch/load; MemWrite=1 for store.
//     If an error exists: MemRead=MemWrite=0, and memory is untouched.
//     At the posedge ending ACCESS:
//       fetch OK -> inst_reg<=Mem_data; load OK -> mem_data_reg<=Mem_data.
//       done<=1 and err/err_code are updated; state goes to IDLE.
//   done is high for exactly the first IDLE cycle after ACCESS.
//   err/err_code hold their value until the next done.
//   inst_reg and mem_data_reg change only on a successful fetch or load respectively.
//   Latency: request accepted at edge E0 -> bus active in cycle E0..E1 -> data and done valid after E1.
//   Throughput: 1 access per 2 cycles. A new request may be presented in the cycle where done=1.
//   reset=1 in any cycle forces MemRead=MemWrite=0 combinationally, so no write commits in that cycle.
//   The next posedge with reset=1 returns to IDLE, clears done/err/err_code, and zeroes inst_reg and mem_data_reg.
//   req_* are ignored while ready=0.
// TESTING
//   Use a bench with the real memory after reset. Word 0=0x20047FFF and word 7=0x08000007.
//   1. Fetch addr 0x0 -> MemRead=1 for 1 cycle; done with err=0; inst_reg=0x20047FFF.
//      Then fetch 0x1C -> inst_reg=0x08000007.
//   2. Store 0xDEADBEEF to 0x80 (word 32), then load 0x80 -> mem_data_reg=0xDEADBEEF, err=0.
//      Back-to-back: the load is issued in the done cycle of the store.
//   3. Store to 0x10 (word 4, protected) -> MemWrite never 1; err=1, err_code=11.
//      A following fetch of 0x10 returns the original word 4.
//   4. Load 0x82 -> err_code=01. Load 0x400 -> err_code=10. Op 11 at 0x402 -> err_code=11.
//      mem_data_reg is unchanged in all three cases.
//   5. Assert reset during the ACCESS cycle of a store to 0x84 -> MemWrite=0 in that cycle;
//      IDLE, ready=1, done=0 after the edge; word 33 reads 0.
//   6. Hold req_valid=1 continuously with alternating ops -> exactly one access per 2 cycles;
//      done pulses never overlap.

Source files
------------

// File: rtl/mem_access_master.sv
// mem_access_master
// CPU-side initiator for the unified instruction/data memory of the multi-cycle CPU.
// Takes one fetch/load/store request at a time and validates its address.
// A request that passes the checks drives the memory bus for exactly one cycle.
// Fetched words are captured into inst_reg, and loaded words into mem_data_reg.
// Completion and any rejection are reported with a one-cycle done pulse.

module mem_access_master #(
   parameter int RAM_SIZE      = 256,
   parameter int RAM_SIZE_BIT  = 8,
   parameter int RAM_INST_SIZE = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [31:0] inst_reg,
   output logic [31:0] mem_data_reg,
   output logic [31:0] Address,
   output logic [31:0] Write_data,
   output logic        MemRead,
   output logic        MemWrite,
   input  logic [31:0] Mem_data
);

   // Request opcodes as presented by the control unit
   localparam logic [1:0] OP_FETCH    = 2'b00;
   localparam logic [1:0] OP_LOAD     = 2'b01;
   localparam logic [1:0] OP_STORE    = 2'b10;
   localparam logic [1:0] OP_RESERVED = 2'b11;

   // Error codes reported alongside done
   localparam logic [1:0] ERR_NONE       = 2'b00;
   localparam logic [1:0] ERR_MISALIGNED = 2'b01;
   localparam logic [1:0] ERR_RANGE      = 2'b10;
   localparam logic [1:0] ERR_PROTECTED  = 2'b11;

   // First word index outside the write-protected instruction region
   localparam logic [RAM_SIZE_BIT-1:0] INST_LIMIT = RAM_INST_SIZE[RAM_SIZE_BIT-1:0];

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  pendCode_q, pendCode_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [1:0]  errCode_q, errCode_d;
   logic [31:0] instReg_q, instReg_d;
   logic [31:0] memData_q, memData_d;

   logic [1:0]  reqCode;
   logic        reqMisaligned;
   logic        reqOutOfRange;
   logic        reqProtected;
   logic        accessOk;

   // Classify the incoming request; the first matching rule wins, so a reserved
   // opcode hides every address problem and misalignment hides a range problem.
   always_comb begin
      reqMisaligned = (req_addr[1:0] != 2'b00);
      reqOutOfRange = (req_addr[31:2] >= 30'(RAM_SIZE));
      reqProtected  = (req_op == OP_STORE) &&
                      (req_addr[RAM_SIZE_BIT+1:2] < INST_LIMIT);
      reqCode = ERR_NONE;
      if (req_op == OP_RESERVED) begin
         reqCode = ERR_PROTECTED;
      end else if (reqMisaligned) begin
         reqCode = ERR_MISALIGNED;
      end else if (reqOutOfRange) begin
         reqCode = ERR_RANGE;
      end else if (reqProtected) begin
         reqCode = ERR_PROTECTED;
      end
   end

   // Next-state logic: IDLE latches a request with its verdict; ACCESS always
   // lasts one cycle and retires the request on its closing edge.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      pendCode_d = pendCode_q;
      done_d     = 1'b0;
      err_d      = err_q;
      errCode_d  = errCode_q;
      instReg_d  = instReg_q;
      memData_d  = memData_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d       = req_op;
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               pendCode_d = reqCode;
               state_d    = ACCESS;
            end
         end
         ACCESS: begin
            state_d   = IDLE;
            done_d    = 1'b1;
            err_d     = (pendCode_q != ERR_NONE);
            errCode_d = pendCode_q;
            if (pendCode_q == ERR_NONE) begin
               if (op_q == OP_FETCH) begin
                  instReg_d = Mem_data;
               end
               if (op_q == OP_LOAD) begin
                  memData_d = Mem_data;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset returns to IDLE and clears every visible result
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         op_q       <= OP_FETCH;
         addr_q     <= '0;
         wdata_q    <= '0;
         pendCode_q <= ERR_NONE;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         errCode_q  <= ERR_NONE;
         instReg_q  <= '0;
         memData_q  <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         pendCode_q <= pendCode_d;
         done_q     <= done_d;
         err_q      <= err_d;
         errCode_q  <= errCode_d;
         instReg_q  <= instReg_d;
         memData_q  <= memData_d;
      end
   end

   // Bus strobes: only a clean request touches memory, and reset gates the
   // strobes immediately so a write cannot commit in a reset cycle.
   always_comb begin
      accessOk = (state_q == ACCESS) && (pendCode_q == ERR_NONE) && !reset;
      MemRead  = accessOk && ((op_q == OP_FETCH) || (op_q == OP_LOAD));
      MemWrite = accessOk && (op_q == OP_STORE);
   end

   assign ready        = (state_q == IDLE);
   assign done         = done_q;
   assign err          = err_q;
   assign err_code     = errCode_q;
   assign inst_reg     = instReg_q;
   assign mem_data_reg = memData_q;
   assign Address      = addr_q;
   assign Write_data   = wdata_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Testbench for mem_access_master: a behavioural RAM sits on the bus.
// A reference model tracks the expected memory contents and register results.
// Directed scenarios are followed by randomized requests.

module tb_mem_access_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [1:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        ready;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [31:0] inst_reg;
   logic [31:0] mem_data_reg;
   logic [31:0] Address;
   logic [31:0] Write_data;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Mem_data;

   int checkCount = 0;
   int errorCount = 0;

   // Memory attached to the bus, plus the reference model's own view of it
   logic [31:0] ram [256];
   logic [31:0] refMem [256];
   logic [31:0] expInst;
   logic [31:0] expMdr;
   logic        expErr;
   logic [1:0]  expCode;

   always #5 clk = ~clk;

   mem_access_master dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .ready        (ready),
      .done         (done),
      .err          (err),
      .err_code     (err_code),
      .inst_reg     (inst_reg),
      .mem_data_reg (mem_data_reg),
      .Address      (Address),
      .Write_data   (Write_data),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .Mem_data     (Mem_data)
   );

   // Combinational read port, returning zero when not reading
   assign Mem_data = MemRead ? ram[Address[9:2]] : 32'h0;

   // Write port commits on the edge that closes the write cycle
   always @(posedge clk) begin
      if (MemWrite) ram[Address[9:2]] <= Write_data;
   end

   // Compare one observed value against the reference model
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Reference verdict for a request, from the rules written as plain arithmetic
   function automatic logic [1:0] refErrCode(input logic [1:0] op, input logic [31:0] addr);
      if (op == 2'd3) return 2'd3;
      if ((addr % 4) != 0) return 2'd1;
      if (addr >= 32'd1024) return 2'd2;
      if (op == 2'd2 && (addr / 4) < 32) return 2'd3;
      return 2'd0;
   endfunction

   // Issue one request from a negedge and check the ACCESS cycle and the done cycle.
   // With holdValid, req_valid stays high and junk is driven while the DUT is busy.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit holdValid,
                                input string name);
      logic [1:0] code;
      int waitCount = 0;
      while (!ready && waitCount < 10) begin
         @(negedge clk);
         waitCount++;
      end
      if (!ready) checkOutput({name, ".readyTimeout"}, 32'd0, 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      code = refErrCode(op, addr);
      @(posedge clk);
      #1;
      if (holdValid) begin
         req_op    = 2'($urandom);
         req_addr  = $urandom;
         req_wdata = $urandom;
      end else begin
         req_valid = 1'b0;
      end
      @(negedge clk);
      checkOutput({name, ".accReady"}, 32'(ready), 32'd0);
      checkOutput({name, ".accDone"}, 32'(done), 32'd0);
      checkOutput({name, ".accRead"}, 32'(MemRead), 32'(code == 2'd0 && op < 2'd2));
      checkOutput({name, ".accWrite"}, 32'(MemWrite), 32'(code == 2'd0 && op == 2'd2));
      checkOutput({name, ".accAddr"}, Address, addr);
      if (op == 2'd2) checkOutput({name, ".accWdata"}, Write_data, wdata);
      checkOutput({name, ".accErrHeld"}, 32'(err), 32'(expErr));
      checkOutput({name, ".accCodeHeld"}, 32'(err_code), 32'(expCode));
      checkOutput({name, ".accInstHeld"}, inst_reg, expInst);
      if (code == 2'd0) begin
         case (op)
            2'd0: expInst = refMem[addr / 4];
            2'd1: expMdr = refMem[addr / 4];
            2'd2: refMem[addr / 4] = wdata;
            default: ;
         endcase
      end
      expErr  = (code != 2'd0);
      expCode = code;
      @(negedge clk);
      checkOutput({name, ".done"}, 32'(done), 32'd1);
      checkOutput({name, ".doneReady"}, 32'(ready), 32'd1);
      checkOutput({name, ".doneRead"}, 32'(MemRead), 32'd0);
      checkOutput({name, ".doneWrite"}, 32'(MemWrite), 32'd0);
      checkOutput({name, ".err"}, 32'(err), 32'(expErr));
      checkOutput({name, ".errCode"}, 32'(err_code), 32'(expCode));
      checkOutput({name, ".instReg"}, inst_reg, expInst);
      checkOutput({name, ".memDataReg"}, mem_data_reg, expMdr);
   endtask

   // Address generator biased towards each error class and the region edges
   function automatic logic [31:0] pickAddr();
      case ($urandom_range(0, 4))
         0: return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         1: return {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
         2: return $urandom | 32'h0000_0400;
         3: return {22'd0, 8'($urandom_range(0, 31)), 2'b00};
         default: return {22'd0, 8'($urandom_range(30, 33)), 2'b00};
      endcase
   endfunction

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [1:0]  rOp;
      logic [31:0] rAddr;
      for (int i = 0; i < 256; i++) begin
         ram[i]    = 32'h0;
         refMem[i] = 32'h0;
      end
      ram[0] = 32'h2004_7FFF; refMem[0] = 32'h2004_7FFF;
      ram[4] = 32'h00A0_B0C0; refMem[4] = 32'h00A0_B0C0;
      ram[7] = 32'h0800_0007; refMem[7] = 32'h0800_0007;
      expInst = 32'h0; expMdr = 32'h0; expErr = 1'b0; expCode = 2'd0;
      reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = 32'h0; req_wdata = 32'h0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst.ready", 32'(ready), 32'd1);
      checkOutput("rst.done", 32'(done), 32'd0);
      checkOutput("rst.err", 32'(err), 32'd0);
      checkOutput("rst.errCode", 32'(err_code), 32'd0);
      checkOutput("rst.inst", inst_reg, 32'h0);
      checkOutput("rst.mdr", mem_data_reg, 32'h0);
      checkOutput("rst.addr", Address, 32'h0);
      checkOutput("rst.wdata", Write_data, 32'h0);
      checkOutput("rst.read", 32'(MemRead), 32'd0);
      checkOutput("rst.write", 32'(MemWrite), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] fetch scenario");
      applyStimulus(2'd0, 32'h0, 32'h0, 1'b0, "fetch0");
      applyStimulus(2'd0, 32'h1C, 32'h0, 1'b0, "fetch7");

      $display("[TB] store then back-to-back load");
      applyStimulus(2'd2, 32'h80, 32'hDEAD_BEEF, 1'b0, "store32");
      applyStimulus(2'd1, 32'h80, 32'h0, 1'b0, "load32");

      $display("[TB] protected store");
      applyStimulus(2'd2, 32'h10, 32'h1111_2222, 1'b0, "protStore");
      applyStimulus(2'd0, 32'h10, 32'h0, 1'b0, "fetch4");

      $display("[TB] address errors");
      applyStimulus(2'd1, 32'h82, 32'h0, 1'b0, "misaligned");
      applyStimulus(2'd1, 32'h400, 32'h0, 1'b0, "outOfRange");
      applyStimulus(2'd3, 32'h402, 32'h0, 1'b0, "reservedOp");

      $display("[TB] reset during a store");
      req_valid = 1'b1; req_op = 2'd2; req_addr = 32'h84; req_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rstAcc.write", 32'(MemWrite), 32'd0);
      checkOutput("rstAcc.read", 32'(MemRead), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      expInst = 32'h0; expMdr = 32'h0; expErr = 1'b0; expCode = 2'd0;
      checkOutput("rstAcc.ready", 32'(ready), 32'd1);
      checkOutput("rstAcc.done", 32'(done), 32'd0);
      checkOutput("rstAcc.err", 32'(err), 32'd0);
      checkOutput("rstAcc.errCode", 32'(err_code), 32'd0);
      checkOutput("rstAcc.inst", inst_reg, 32'h0);
      checkOutput("rstAcc.mdr", mem_data_reg, 32'h0);
      checkOutput("rstAcc.word33", ram[33], 32'h0);
      applyStimulus(2'd1, 32'h84, 32'h0, 1'b0, "load33");

      $display("[TB] continuous requests with alternating ops");
      for (int i = 0; i < 8; i++) begin
         rOp = (i % 2 == 0) ? 2'd2 : 2'd1;
         applyStimulus(rOp, 32'h100 + 32'((i / 2) * 4), $urandom, 1'b1, "stream");
      end
      req_valid = 1'b0;
      @(negedge clk);

      $display("[TB] randomized requests");
      for (int i = 0; i < 40; i++) begin
         rOp   = 2'($urandom_range(0, 3));
         rAddr = pickAddr();
         applyStimulus(rOp, rAddr, $urandom, 1'($urandom_range(0, 1)), "random");
      end
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
